input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 N_SW, 16, number of slide switches.
REQ-002 N_COL, 5, key-matrix columns driven by btn_x.
REQ-003 N_ROW, 5, key-matrix rows read on btn_y.
REQ-004 SCAN_CYC, 50000, clk cycles per column dwell; legal range is SCAN_CYC >= 4.
REQ-005 TICK_CYC, 100000, clk cycles between debounce samples; legal range is TICK_CYC >= 1.
REQ-006 DEB_N, 4, consecutive equal samples required to accept a new debounced level; legal range is DEB_N >= 2.
REQ-007 RST_KEY, 0, key index used for the long-press reset.
REQ-008 LONG_CYC, 200000000, hold time in clk cycles before long_rst asserts.
REQ-009 clk  in  1  single system clock; all logic is on the rising edge.
REQ-010 rst  in  1  synchronous reset, active-high.
REQ-011 switch  in  N_SW  raw asynchronous slide switches, active-high.
REQ-012 btn_x  out  N_COL  column drive, one-hot active-low.
REQ-013 btn_y  in  N_ROW  raw asynchronous row sense; low means pressed.
REQ-014 sw_ok  out  N_SW  debounced switch levels.
REQ-015 btn_ok  out  N_COL*N_ROW  debounced key levels; 1 means pressed.
REQ-016 btn_press  out  N_COL*N_ROW  one-cycle pulse on each debounced 0->1 key transition.
REQ-017 sw_chg  out  N_SW  one-cycle pulse on any debounced switch transition.
REQ-018 cr  out  1  equal to btn_ok[RST_KEY].
REQ-019 long_rst  out  1  high while key RST_KEY has been held for at least LONG_CYC cycles.

Function
REQ-020 switch and btn_y SHALL each pass through a 2-flop synchronizer before any use.
REQ-021 Scan FSM: a column index col and a dwell counter dcnt SHALL count dcnt 0..SCAN_CYC-1; btn_x = ~(1<<col).
REQ-022 When dcnt==SCAN_CYC-1, the block SHALL latch the inverted synchronized btn_y into raw[col*N_ROW +: N_ROW], set dcnt to 0, and advance col, wrapping from N_COL-1 to 0.
REQ-023 Key index k SHALL equal col*N_ROW+row.
REQ-024 A tick SHALL pulse for one cycle every TICK_CYC cycles, free-running from reset.
REQ-025 On each tick, every debounce channel (N_SW synchronized switches plus all raw keys) SHALL shift its current input into a DEB_N-bit history.
REQ-026 On a tick, a debounced output SHALL take the new level only when all DEB_N history bits, including the sample just shifted, equal that level; otherwise the output holds.
REQ-027 A glitch shorter than DEB_N ticks SHALL never change sw_ok or btn_ok.
REQ-028 btn_press[k] and sw_chg[i] SHALL be high exactly in the cycle after the corresponding debounced output changes, and only for that cycle.
REQ-029 btn_press[k] SHALL NOT pulse on release.
REQ-030 A simultaneous change on multiple channels SHALL produce pulses on all of them in the same cycle.
REQ-031 The long-press counter SHALL increment while cr==1, saturate at LONG_CYC (no wrap), and clear to 0 in the cycle after cr==0.
REQ-032 long_rst SHALL be high when count >= LONG_CYC.
REQ-033 The long-press counter SHALL be $clog2(LONG_CYC+1) bits wide.
REQ-034 Releasing the key in the same cycle the count reaches LONG_CYC SHALL still give one long_rst cycle.

Reset
REQ-035 While rst=1, the block SHALL drive: col=0, dcnt=0, btn_x = ~1, tick counter=0, raw=0, all histories=0, sw_ok=0, btn_ok=0, btn_press=0, sw_chg=0, long-press count=0, long_rst=0.
REQ-036 Synchronizer flops SHALL also reset to 0.
REQ-037 Reset asserted mid-scan or mid-hold SHALL abort without emitting pulses.
REQ-038 After rst deasserts, the first column dwell SHALL start at dcnt=0.

Verification (params N_SW=2, N_COL=2, N_ROW=2, SCAN_CYC=4, TICK_CYC=8, DEB_N=3, RST_KEY=3, LONG_CYC=20)
REQ-039 Scan: after rst release with btn_y=2'b11, btn_x SHALL follow 10,10,10,10,01,01,01,01, then repeat; btn_ok SHALL stay 0.
REQ-040 Debounce: switch[0] driven to 1 and held SHALL make sw_ok[0] rise on the 3rd tick after synchronized sampling, with sw_chg[0] pulsing for one cycle; a 1-tick switch glitch SHALL leave sw_ok unchanged.
REQ-041 Key press: btn_y[1]=0 only while btn_x==01 (key 3) and held SHALL give btn_ok[3]=1, cr=1, and exactly one btn_press[3] pulse; release SHALL give btn_ok[3]=0 with no btn_press pulse.
REQ-042 Long press: holding key 3 SHALL raise long_rst 20 cycles after cr rises; long_rst SHALL stay high while held and drop the cycle after cr falls.
REQ-043 Reset mid-operation: asserting rst at count=10 SHALL drive all outputs 0 next cycle, and counting SHALL restart only after a fresh debounce.
REQ-044 Simultaneous: key 0 and key 3 pressed in the same scan frame SHALL pulse btn_press[0] and btn_press[3] on the same tick cycle.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner
//   Front end for a board with slide switches and a scanned key matrix.
//   Raw switches and matrix rows are synchronized, the matrix is scanned
//   one column at a time, and every switch and key is debounced against a
//   slow sample tick.  Edge pulses are generated from the debounced levels,
//   and one key doubles as a long-press reset request.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   switch     raw slide switches (asynchronous, active-high)
//   btn_x      matrix column drive, one-hot active-low
//   btn_y      raw matrix row sense (asynchronous, low = pressed)
//   sw_ok      debounced switch levels
//   btn_ok     debounced key levels, key k = col*N_ROW + row, 1 = pressed
//   btn_press  one-cycle pulse per debounced key press (never on release)
//   sw_chg     one-cycle pulse per debounced switch change (either way)
//   cr         debounced level of key RST_KEY
//   long_rst   high while key RST_KEY has been held for LONG_CYC cycles
//
// Pulse semantics: btn_press/sw_chg are high for exactly the one cycle
// after the debounced level changes; there is no handshake, consumers
// sample them every cycle.
module input_conditioner #(
  parameter int N_SW     = 16,
  parameter int N_COL    = 5,
  parameter int N_ROW    = 5,
  parameter int SCAN_CYC = 50000,
  parameter int TICK_CYC = 100000,
  parameter int DEB_N    = 4,
  parameter int RST_KEY  = 0,
  parameter int LONG_CYC = 200000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SW-1:0]        switch,
  output logic [N_COL-1:0]       btn_x,
  input  logic [N_ROW-1:0]       btn_y,
  output logic [N_SW-1:0]        sw_ok,
  output logic [N_COL*N_ROW-1:0] btn_ok,
  output logic [N_COL*N_ROW-1:0] btn_press,
  output logic [N_SW-1:0]        sw_chg,
  output logic                   cr,
  output logic                   long_rst
);

  localparam int N_KEY = N_COL * N_ROW;
  localparam int N_CH  = N_SW + N_KEY;
  localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int DC_W  = $clog2(SCAN_CYC);
  localparam int TC_W  = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int LC_W  = $clog2(LONG_CYC + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(SCAN_CYC - 1);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TICK_CYC - 1);
  localparam logic [LC_W-1:0]  LC_MAX   = LC_W'(LONG_CYC);

  // ---------------------------------------------------------------
  // Two-flop synchronizers
  // ---------------------------------------------------------------
  logic [N_SW-1:0]  sw_s1, sw_s2;
  logic [N_ROW-1:0] by_s1, by_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      by_s1 <= '0;
      by_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      by_s1 <= btn_y;
      by_s2 <= by_s1;
    end
  end

  // ---------------------------------------------------------------
  // Matrix scan.  Rows are latched on the last dwell cycle so the row
  // lines have had the full two-flop delay to reflect the current column
  // (this is why SCAN_CYC must be at least 4).
  // ---------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [DC_W-1:0]  dcnt;
  logic [N_KEY-1:0] raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      dcnt <= '0;
      raw  <= '0;
    end else if (dcnt == DC_LAST) begin
      for (int c = 0; c < N_COL; c++) begin
        if (col == COL_W'(c)) raw[c*N_ROW +: N_ROW] <= ~by_s2;
      end
      dcnt <= '0;
      col  <= (col == COL_LAST) ? '0 : col + 1'b1;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  always_comb begin
    btn_x = '1;
    for (int c = 0; c < N_COL; c++) begin
      if (col == COL_W'(c)) btn_x[c] = 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // Debounce sample tick, free-running from reset
  // ---------------------------------------------------------------
  logic [TC_W-1:0] tcnt;
  logic            tick;

  always_ff @(posedge clk) begin
    if (rst) tcnt <= '0;
    else     tcnt <= (tcnt == TC_LAST) ? '0 : tcnt + 1'b1;
  end

  assign tick = (tcnt == TC_LAST);

  // ---------------------------------------------------------------
  // Debounce: channel order is {keys, switches}.  A level is accepted
  // only when the whole history (including the newest sample) agrees.
  // ---------------------------------------------------------------
  logic [N_CH-1:0]  deb_in;
  logic [DEB_N-1:0] hist    [N_CH];
  logic [DEB_N-1:0] hist_nx [N_CH];
  logic [N_CH-1:0]  ok;
  logic [N_CH-1:0]  ok_d;

  assign deb_in = {raw, sw_s2};

  always_comb begin
    for (int ch = 0; ch < N_CH; ch++) begin
      hist_nx[ch] = {hist[ch][DEB_N-2:0], deb_in[ch]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) hist[ch] <= '0;
      ok <= '0;
    end else if (tick) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch] <= hist_nx[ch];
        if (&hist_nx[ch])       ok[ch] <= 1'b1;
        else if (~|hist_nx[ch]) ok[ch] <= 1'b0;
      end
    end
  end

  // Edge pulses compare the debounced level with its one-cycle-old copy,
  // so they appear the cycle after the level changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_d      <= '0;
      btn_press <= '0;
      sw_chg    <= '0;
    end else begin
      ok_d      <= ok;
      btn_press <= ok[N_CH-1:N_SW] & ~ok_d[N_CH-1:N_SW];
      sw_chg    <= ok[N_SW-1:0] ^ ok_d[N_SW-1:0];
    end
  end

  assign sw_ok  = ok[N_SW-1:0];
  assign btn_ok = ok[N_CH-1:N_SW];
  assign cr     = btn_ok[RST_KEY];

  // ---------------------------------------------------------------
  // Long-press counter: saturates, cleared the cycle after cr drops
  // ---------------------------------------------------------------
  logic [LC_W-1:0] lcnt;

  always_ff @(posedge clk) begin
    if (rst)                  lcnt <= '0;
    else if (!cr)             lcnt <= '0;
    else if (lcnt != LC_MAX)  lcnt <= lcnt + 1'b1;
  end

  assign long_rst = (lcnt >= LC_MAX);

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed bench for input_conditioner with small parameters
//   (N_SW=2, 2x2 matrix, SCAN_CYC=4, TICK_CYC=8, DEB_N=3, RST_KEY=3,
//   LONG_CYC=20).  Pulse events are scoreboarded with their expected
//   cycle; steady levels are checked directly at hand-computed cycles.
//   Cycle numbers below are counted in rising edges after the last
//   reset edge of each phase.
module tb_input_conditioner;

  localparam int W = 28;  // {cycle[15:0], press[3:0], chg[1:0], btn_ok[3:0], sw_ok[1:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] switch;
  logic [1:0] btn_x;
  logic [1:0] btn_y;
  logic [1:0] sw_ok;
  logic [3:0] btn_ok;
  logic [3:0] btn_press;
  logic [1:0] sw_chg;
  logic       cr;
  logic       long_rst;

  logic [3:0] key_down;

  input_conditioner #(
    .N_SW(2), .N_COL(2), .N_ROW(2), .SCAN_CYC(4), .TICK_CYC(8),
    .DEB_N(3), .RST_KEY(3), .LONG_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .btn_x(btn_x), .btn_y(btn_y),
    .sw_ok(sw_ok), .btn_ok(btn_ok), .btn_press(btn_press), .sw_chg(sw_chg),
    .cr(cr), .long_rst(long_rst)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive key matrix: a held key pulls its row low while its column is driven.
  assign btn_y[0] = ~((~btn_x[0] & key_down[0]) | (~btn_x[1] & key_down[2]));
  assign btn_y[1] = ~((~btn_x[0] & key_down[1]) | (~btn_x[1] & key_down[3]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int base     = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - base);
  endtask

  task automatic push_evt(input int at, input logic [3:0] p, input logic [1:0] c,
                          input logic [3:0] bo, input logic [1:0] so);
    exp_q.push_back({16'(at), p, c, bo, so});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (btn_press != 4'd0 || sw_chg != 2'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({btn_press, sw_chg}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle",     32'(cyc[15:0]), 32'(e[27:12]));
        check("pulse_btn_press", 32'(btn_press), 32'(e[11:8]));
        check("pulse_sw_chg",    32'(sw_chg),    32'(e[7:6]));
        check("pulse_btn_ok",    32'(btn_ok),    32'(e[5:2]));
        check("pulse_sw_ok",     32'(sw_ok),     32'(e[1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    base = cyc;
    rst  = 1'b0;
  endtask

  task automatic wait_to(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw_ok"},     32'(sw_ok),     32'd0);
    check({tag, "_btn_ok"},    32'(btn_ok),    32'd0);
    check({tag, "_btn_press"}, 32'(btn_press), 32'd0);
    check({tag, "_sw_chg"},    32'(sw_chg),    32'd0);
    check({tag, "_cr"},        32'(cr),        32'd0);
    check({tag, "_long_rst"},  32'(long_rst),  32'd0);
    check({tag, "_btn_x"},     32'(btn_x),     32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    switch   = 2'b00;
    key_down = 4'b0000;

    // Reset state and column scan with no keys held
    do_reset(3);
    check_all_zero("reset");
    for (int n = 1; n <= 16; n++) begin
      logic [1:0] exp_x;
      wait_to(n);
      exp_x = (((n / 4) % 2) == 1) ? 2'b01 : 2'b10;
      check("scan_btn_x", 32'(btn_x), 32'(exp_x));
    end
    check("scan_btn_ok", 32'(btn_ok), 32'd0);

    // Switch debounce, one-tick glitches, release
    do_reset(2);
    switch[0] = 1'b1;
    push_evt(base + 25, 4'b0000, 2'b01, 4'b0000, 2'b01);
    wait_to(23); check("sw_before_accept", 32'(sw_ok), 32'd0);
    wait_to(24); check("sw_accept", 32'(sw_ok), 32'd1);
    wait_to(26); switch[1] = 1'b1;
    wait_to(34); switch[1] = 1'b0; switch[0] = 1'b0;
    wait_to(42); switch[0] = 1'b1;
    wait_to(47); check("sw_glitch_hold", 32'(sw_ok), 32'd1);
    wait_to(48); switch[0] = 1'b0;
    push_evt(base + 73, 4'b0000, 2'b01, 4'b0000, 2'b00);
    wait_to(71); check("sw_before_release", 32'(sw_ok), 32'd1);
    wait_to(72); check("sw_release", 32'(sw_ok), 32'd0);
    wait_to(80);

    // Key 3 press, long press, release
    do_reset(2);
    key_down[3] = 1'b1;
    push_evt(base + 33, 4'b1000, 2'b00, 4'b1000, 2'b00);
    wait_to(31); check("key_cr_before", 32'(cr), 32'd0);
                 check("key_ok_before", 32'(btn_ok), 32'd0);
    wait_to(32); check("key_cr_rise", 32'(cr), 32'd1);
                 check("key_ok_rise", 32'(btn_ok), 32'h8);
    wait_to(51); check("long_before", 32'(long_rst), 32'd0);
    wait_to(52); check("long_rise", 32'(long_rst), 32'd1);
    wait_to(60); check("long_hold", 32'(long_rst), 32'd1);
    key_down[3] = 1'b0;
    wait_to(87); check("key_ok_still", 32'(btn_ok), 32'h8);
    wait_to(88); check("key_ok_release", 32'(btn_ok), 32'd0);
                 check("key_cr_fall", 32'(cr), 32'd0);
                 check("long_at_cr_fall", 32'(long_rst), 32'd1);
    wait_to(89); check("long_fall", 32'(long_rst), 32'd0);
    wait_to(100);

    // Reset in the middle of a long press
    do_reset(2);
    key_down[3] = 1'b1;
    push_evt(base + 33, 4'b1000, 2'b00, 4'b1000, 2'b00);
    wait_to(42); check("mid_cr", 32'(cr), 32'd1);
                 check("mid_long", 32'(long_rst), 32'd0);
    do_reset(1);
    check_all_zero("midrst");
    push_evt(base + 33, 4'b1000, 2'b00, 4'b1000, 2'b00);
    wait_to(31); check("redeb_cr_before", 32'(cr), 32'd0);
    wait_to(32); check("redeb_cr_rise", 32'(cr), 32'd1);
    wait_to(51); check("redeb_long_before", 32'(long_rst), 32'd0);
    wait_to(52); check("redeb_long_rise", 32'(long_rst), 32'd1);
    key_down = 4'b0000;
    wait_to(60);

    // Keys 0 and 3 plus switch 1 accepted on the same tick
    switch = 2'b00;
    do_reset(2);
    key_down[3] = 1'b1;
    push_evt(base + 33, 4'b1001, 2'b10, 4'b1001, 2'b10);
    wait_to(4);  key_down[0] = 1'b1;
    wait_to(8);  switch[1] = 1'b1;
    wait_to(31); check("simul_ok_before", 32'(btn_ok), 32'd0);
    wait_to(32); check("simul_ok", 32'(btn_ok), 32'h9);
                 check("simul_sw_ok", 32'(sw_ok), 32'd2);
    wait_to(40);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
